// File: rtl/mux2a1_cond_l2.sv
// mux2a1_cond_l2 -- layer-2 interleaver (2 byte lanes -> 1 byte stream).
//
// Each lane has a DEPTH-entry FIFO that absorbs arrival skew. The output
// takes bytes strictly alternately from lane 0 and lane 1, so the original
// byte order is restored. If the selected lane is empty, the output waits
// on that lane and never skips to the other one.
//
// Optional feature: define MUX_OVF_FLAG_EN to add the err_ovf port. err_ovf
// is a sticky flag that is set when a byte is dropped on either lane.
//
// Handshake: validN marks a byte on data_inN_muxL2 for one cycle only. There
// is no ready signal. If a byte arrives at a full lane and that lane is not
// popped on the same edge, the byte is dropped. validout marks
// dataout_muxL2 as valid for exactly the cycle that follows the pop edge.
module mux2a1_cond_l2 #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic       clk_4f,
  input  logic       reset_L,
  input  logic       valid0,
  input  logic [7:0] data_in0_muxL2,
  input  logic       valid1,
  input  logic [7:0] data_in1_muxL2,
  output logic       validout,
  output logic [7:0] dataout_muxL2,
  output logic       full0,
  output logic       full1
`ifdef MUX_OVF_FLAG_EN
  ,
  output logic       err_ovf
`endif
);

  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [7:0]    mem0_q [DEPTH];
  logic [7:0]    mem1_q [DEPTH];
  logic [AW-1:0] wr0_q, rd0_q, wr1_q, rd1_q;
  logic [AW:0]   cnt0_q, cnt1_q, cnt0_d, cnt1_d;
  logic          sel_q;
  logic          valid_q;
  logic [7:0]    data_q;
  logic          full0_q, full1_q;
  logic          pop0, pop1, push0, push1;

  // Decide this edge's pop and pushes. The decision uses the counts from
  // before the edge, so a byte cannot pass straight through the FIFO.
  always_comb begin
    pop0  = ~sel_q & (cnt0_q != '0);
    pop1  =  sel_q & (cnt1_q != '0);
    push0 = valid0 & ((cnt0_q != CNT_FULL) | pop0);
    push1 = valid1 & ((cnt1_q != CNT_FULL) | pop1);
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (push0 & ~pop0) cnt0_d = cnt0_q + CNT_ONE;
    if (~push0 & pop0) cnt0_d = cnt0_q - CNT_ONE;
    if (push1 & ~pop1) cnt1_d = cnt1_q + CNT_ONE;
    if (~push1 & pop1) cnt1_d = cnt1_q - CNT_ONE;
  end

  // FIFO storage. It has no reset because an entry is only read after a
  // byte has been written into it.
  always_ff @(posedge clk_4f) begin
    if (push0) mem0_q[wr0_q] <= data_in0_muxL2;
    if (push1) mem1_q[wr1_q] <= data_in1_muxL2;
  end

  // Pointers, counts, full flags, lane select and the registered output.
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      wr0_q   <= '0;
      rd0_q   <= '0;
      wr1_q   <= '0;
      rd1_q   <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      full0_q <= 1'b0;
      full1_q <= 1'b0;
      sel_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      if (push0) wr0_q <= wr0_q + PTR_ONE;
      if (push1) wr1_q <= wr1_q + PTR_ONE;
      if (pop0)  rd0_q <= rd0_q + PTR_ONE;
      if (pop1)  rd1_q <= rd1_q + PTR_ONE;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      full0_q <= (cnt0_d == CNT_FULL);
      full1_q <= (cnt1_d == CNT_FULL);
      // If the selected lane is empty, the output holds its last byte and
      // the lane select does not change.
      valid_q <= pop0 | pop1;
      if (pop0) data_q <= mem0_q[rd0_q];
      if (pop1) data_q <= mem1_q[rd1_q];
      if (pop0 | pop1) sel_q <= ~sel_q;
    end
  end

`ifdef MUX_OVF_FLAG_EN
  logic err_q;

  // Sticky overflow flag. It is set when a byte arrives at a lane that
  // cannot accept it.
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      err_q <= 1'b0;
    end else if ((valid0 & ~push0) | (valid1 & ~push1)) begin
      err_q <= 1'b1;
    end
  end

  assign err_ovf = err_q;
`endif

  assign validout      = valid_q;
  assign dataout_muxL2 = data_q;
  assign full0         = full0_q;
  assign full1         = full1_q;

endmodule

// File: tb/tb_mux2a1_cond_l2.sv
// Testbench for mux2a1_cond_l2. A queue-based model of the interleaver
// computes the expected outputs. The bench compares the DUT outputs with
// the model after every clock edge and after every asynchronous reset.
module tb_mux2a1_cond_l2;

  localparam int DEPTH = 4;

  logic       clk_4f;
  logic       reset_L;
  logic       valid0, valid1;
  logic [7:0] data_in0_muxL2, data_in1_muxL2;
  logic       validout;
  logic [7:0] dataout_muxL2;
  logic       full0, full1;
  logic       err_ovf;

  int n_checks;
  int n_errors;

  // Reference model: one byte queue per lane plus the lane pointer.
  logic [7:0] lane_q0[$];
  logic [7:0] lane_q1[$];
  bit         m_sel;
  logic       exp_valid;
  logic [7:0] exp_data;
  logic       exp_err;

  mux2a1_cond_l2 #(.DEPTH(DEPTH), .AW(2)) dut (
    .clk_4f         (clk_4f),
    .reset_L        (reset_L),
    .valid0         (valid0),
    .data_in0_muxL2 (data_in0_muxL2),
    .valid1         (valid1),
    .data_in1_muxL2 (data_in1_muxL2),
    .validout       (validout),
    .dataout_muxL2  (dataout_muxL2),
    .full0          (full0),
    .full1          (full1)
`ifdef MUX_OVF_FLAG_EN
    ,
    .err_ovf        (err_ovf)
`endif
  );

`ifndef MUX_OVF_FLAG_EN
  assign err_ovf = 1'b0;
`endif

  // Clock and reset.
  initial clk_4f = 1'b0;
  always #5 clk_4f = ~clk_4f;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string phase);
    check({phase, " validout"}, {31'd0, validout}, {31'd0, exp_valid});
    check({phase, " dataout"},  {24'd0, dataout_muxL2}, {24'd0, exp_data});
    check({phase, " full0"},    {31'd0, full0}, {31'd0, (lane_q0.size() == DEPTH)});
    check({phase, " full1"},    {31'd0, full1}, {31'd0, (lane_q1.size() == DEPTH)});
`ifdef MUX_OVF_FLAG_EN
    check({phase, " err_ovf"},  {31'd0, err_ovf}, {31'd0, exp_err});
`endif
  endtask

  task automatic model_reset();
    lane_q0.delete();
    lane_q1.delete();
    m_sel     = 1'b0;
    exp_valid = 1'b0;
    exp_data  = 8'h00;
    exp_err   = 1'b0;
  endtask

  // One clock edge of the model. A lane accepts a byte if it had space
  // before the edge or if it gives up its head on the same edge.
  task automatic model_step(input bit v0, input logic [7:0] d0, input bit v1, input logic [7:0] d1);
    int  s0, s1;
    bit  popped0, popped1;
    s0 = lane_q0.size();
    s1 = lane_q1.size();
    popped0 = 1'b0;
    popped1 = 1'b0;
    exp_valid = 1'b0;
    if (!m_sel && s0 > 0) begin
      exp_data = lane_q0.pop_front();
      exp_valid = 1'b1;
      popped0 = 1'b1;
      m_sel = 1'b1;
    end else if (m_sel && s1 > 0) begin
      exp_data = lane_q1.pop_front();
      exp_valid = 1'b1;
      popped1 = 1'b1;
      m_sel = 1'b0;
    end
    if (v0) begin
      if (s0 < DEPTH || popped0) lane_q0.push_back(d0);
      else exp_err = 1'b1;
    end
    if (v1) begin
      if (s1 < DEPTH || popped1) lane_q1.push_back(d1);
      else exp_err = 1'b1;
    end
  endtask

  // Driver: set the inputs, let one edge pass, then check the outputs
  // 1 ns after the edge.
  task automatic cycle(input string phase, input bit v0, input logic [7:0] d0,
                       input bit v1, input logic [7:0] d1);
    valid0 = v0;
    data_in0_muxL2 = d0;
    valid1 = v1;
    data_in1_muxL2 = d1;
    @(posedge clk_4f);
    model_step(v0, d0, v1, d1);
    #1;
    check_outputs(phase);
  endtask

  task automatic idle(input string phase, input int n);
    for (int i = 0; i < n; i++) cycle(phase, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  // Assert reset in the middle of the cycle, check the outputs at once,
  // then release reset away from the rising edge.
  task automatic async_reset(input string phase);
    valid0 = 1'b0;
    valid1 = 1'b0;
    #2;
    reset_L = 1'b0;
    #1;
    model_reset();
    check_outputs(phase);
    @(posedge clk_4f);
    #1;
    check_outputs(phase);
    @(negedge clk_4f);
    reset_L = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    valid0 = 1'b0;
    valid1 = 1'b0;
    data_in0_muxL2 = 8'h00;
    data_in1_muxL2 = 8'h00;
    reset_L = 1'b1;
    model_reset();
    @(posedge clk_4f);
    #1;
    async_reset("reset");

    // Interleave: pairs arrive on the same cycle.
    cycle("interleave", 1'b1, 8'hA0, 1'b1, 8'hA1);
    cycle("interleave", 1'b1, 8'hA2, 1'b1, 8'hA3);
    cycle("interleave", 1'b1, 8'hA4, 1'b1, 8'hA5);
    idle("interleave", 5);

    // Skew: lane 1 arrives three cycles after lane 0.
    cycle("skew", 1'b1, 8'h11, 1'b0, 8'h00);
    idle("skew", 2);
    cycle("skew", 1'b0, 8'h00, 1'b1, 8'h22);
    idle("skew", 3);

    // Full: lane 0 only. The sixth byte reaches a full lane and is dropped.
    for (int i = 0; i < 6; i++) cycle("full", 1'b1, 8'(8'h10 + i), 1'b0, 8'h00);
    idle("full", 2);
    for (int i = 0; i < 5; i++) cycle("full_drain", 1'b0, 8'h00, 1'b1, 8'(8'h30 + i));
    idle("full_drain", 10);
    async_reset("reset_after_full");

    // Wrap: 12 pairs streamed back to back, so the pointers wrap.
    for (int i = 0; i < 12; i++)
      cycle("wrap", 1'b1, 8'(2 * i), 1'b1, 8'(2 * i + 1));
    idle("wrap", 4);

    // Reset while bytes are buffered, then send a fresh pair.
    cycle("mid", 1'b1, 8'h51, 1'b0, 8'h00);
    cycle("mid", 1'b1, 8'h53, 1'b0, 8'h00);
    cycle("mid", 1'b1, 8'h55, 1'b0, 8'h00);
    cycle("mid", 1'b1, 8'h57, 1'b0, 8'h00);
    async_reset("reset_mid");
    cycle("after_reset", 1'b1, 8'hB0, 1'b1, 8'hB1);
    idle("after_reset", 3);

    // Random traffic. Phase 0 keeps the lanes balanced. Phases 1 and 2
    // starve one lane so that the other lane fills up and drops bytes.
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 200; i++) begin
        bit v0, v1;
        v0 = ($urandom_range(0, 3) != 0);
        v1 = ($urandom_range(0, 3) != 0);
        if (ph == 1) v1 = ($urandom_range(0, 7) == 0);
        if (ph == 2) v0 = ($urandom_range(0, 7) == 0);
        cycle("random", v0, 8'($urandom_range(0, 255)), v1, 8'($urandom_range(0, 255)));
      end
      idle("random_drain", 12);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
